pe_array_ctrl: RTL

//  Sequencer for one pe_array tile operation. Per run it issues, in order:
//  - accumulator clear
//  - optional weight load
//  - NUM_STEPS gated enable beats
//  It then holds results until downstream accepts them. It sits between the tile scheduler and pe_array.

---
 rtl/pe_ctrl_pkg.sv | 18 +
 rtl/pe_ctrl_perf.sv | 48 ++++
 rtl/pe_array_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared state encoding and constants for pe_array_ctrl
package pe_ctrl_pkg;

    localparam int STEP_W_DEF    = 16;
    localparam int PERF_W_DEF    = 32;
    localparam int CLEAR_CYCLES  = 1;
    localparam int SETTLE_CYCLES = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD_W  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_RESULT  = 3'd5
    } state_e;

endpackage

// File: rtl/pe_ctrl_perf.sv
// rtl/pe_ctrl_perf.sv - saturating busy/stall cycle counters for pe_array_ctrl
module pe_ctrl_perf
    import pe_ctrl_pkg::*;
#(
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              run_inc,
    input  logic              stall_inc,
    output logic [PERF_W-1:0] perf_run,
    output logic [PERF_W-1:0] perf_stall
);

    logic [PERF_W-1:0] run_q, run_d;
    logic [PERF_W-1:0] stall_q, stall_d;

    always_comb begin
        run_d   = run_q;
        stall_d = stall_q;
        if (clr) begin
            run_d   = '0;
            stall_d = '0;
        end else begin
            if (run_inc && run_q != '1) begin
                run_d = run_q + PERF_W'(1);
            end
            if (stall_inc && stall_q != '1) begin
                stall_d = stall_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= '0;
            stall_q <= '0;
        end else begin
            run_q   <= run_d;
            stall_q <= stall_d;
        end
    end

    assign perf_run   = run_q;
    assign perf_stall = stall_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - pe_array tile-run sequencer; PE_ARRAY_CTRL_PERF_EN adds perf counters
module pe_array_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              keep_weights,
    input  logic              abort,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic              d_valid,
    output logic              d_ready,
    output logic              pe_acc_clear,
    output logic              pe_weight_load,
    output logic              pe_enable,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_cnt,
    output logic [PERF_W-1:0] perf_run,
    output logic [PERF_W-1:0] perf_stall
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] num_steps_q, num_steps_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              keep_q, keep_d;
    logic [1:0]        phase_q, phase_d;

    always_comb begin
        state_d     = state_q;
        num_steps_d = num_steps_q;
        step_cnt_d  = step_cnt_q;
        keep_d      = keep_q;
        phase_d     = phase_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_steps_d = num_steps;
                        keep_d      = keep_weights;
                        state_d     = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    step_cnt_d = '0;
                    if (phase_q == 2'(CLEAR_CYCLES - 1)) begin
                        phase_d = '0;
                        if (num_steps_q == '0) begin
                            state_d = ST_SETTLE;
                        end else if (keep_q) begin
                            state_d = ST_COMPUTE;
                        end else begin
                            state_d = ST_LOAD_W;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
                ST_LOAD_W: begin
                    if (w_valid) begin
                        state_d = ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (d_valid) begin
                        if (step_cnt_q != num_steps_q) begin
                            step_cnt_d = step_cnt_q + STEP_W'(1);
                        end
                        if (step_cnt_q == num_steps_q - STEP_W'(1)) begin
                            state_d = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Covers the pe_array accumulator register latency.
                    if (phase_q == 2'(SETTLE_CYCLES - 1)) begin
                        phase_d = '0;
                        state_d = ST_RESULT;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_steps_q <= '0;
            step_cnt_q  <= '0;
            keep_q      <= 1'b0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            num_steps_q <= num_steps_d;
            step_cnt_q  <= step_cnt_d;
            keep_q      <= keep_d;
            phase_q     <= phase_d;
        end
    end

    // Strobes are decoded from the current state so they line up with the vector on the bus.
    assign busy           = (state_q != ST_IDLE);
    assign w_ready        = (state_q == ST_LOAD_W);
    assign d_ready        = (state_q == ST_COMPUTE);
    assign pe_acc_clear   = (state_q == ST_CLEAR);
    assign pe_weight_load = (state_q == ST_LOAD_W) && w_valid && !abort;
    assign pe_enable      = (state_q == ST_COMPUTE) && d_valid && !abort;
    assign res_valid      = (state_q == ST_RESULT);
    assign done           = (state_q == ST_RESULT) && res_ready && !abort;
    assign step_cnt       = step_cnt_q;

`ifdef PE_ARRAY_CTRL_PERF_EN
    pe_ctrl_perf #(
        .PERF_W(PERF_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .clr       ((state_q == ST_IDLE) && start),
        .run_inc   (busy),
        .stall_inc ((state_q == ST_COMPUTE) && !d_valid),
        .perf_run  (perf_run),
        .perf_stall(perf_stall)
    );
`else
    assign perf_run   = '0;
    assign perf_stall = '0;
`endif

endmodule
